// File: rtl/instruction_fetch_pkg.sv
// Shared widths and FSM state encoding for the instruction fetch unit.
package instruction_fetch_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory bus plus the IR handshake toward the decoder.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  addr_t  mem_addr;
  logic   mem_req;
  logic   mem_ack;
  instr_t mem_data;
  instr_t IR;
  addr_t  ir_addr;
  logic   ir_valid;
  logic   ir_ready;

  modport master (
    output mem_addr, mem_req, IR, ir_addr, ir_valid,
    input  mem_ack, mem_data, ir_ready
  );

  modport slave (
    input  mem_addr, mem_req, IR, ir_addr, ir_valid,
    output mem_ack, mem_data, ir_ready
  );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: requests one word per PC value, presents it on IR with a
// one-entry skid buffer for decoder back-pressure, and handles branch flushes.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  addr_t PC,
  output logic  pc_ce,
  input  logic  flush,
  instruction_fetch_if.master bus
);

  fetch_state_t state, state_d;

  addr_t  addr_q, ir_addr_q, skid_addr;
  instr_t ir_q, skid_data;
  logic   ir_valid_q;

  logic inc, take_mem, take_skid, to_skid, capture, req;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    req       = 1'b0;
    inc       = 1'b0;
    take_mem  = 1'b0;
    take_skid = 1'b0;
    to_skid   = 1'b0;
    capture   = 1'b0;
    case (state)
      LOAD: begin
        capture = 1'b1;
        state_d = flush ? LOAD : REQ;
      end
      REQ: begin
        req = 1'b1;
        // A request is never withdrawn: flush without ack waits it out in DRAIN.
        if (flush) begin
          state_d = bus.mem_ack ? LOAD : DRAIN;
        end else if (bus.mem_ack) begin
          if (!ir_valid_q || bus.ir_ready) begin
            take_mem = 1'b1;
            inc      = 1'b1;
            state_d  = LOAD;
          end else begin
            to_skid = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = LOAD;
        end else if (bus.ir_ready) begin
          take_skid = 1'b1;
          inc       = 1'b1;
          state_d   = LOAD;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (bus.mem_ack) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // The skid entry is occupied exactly while in HOLD, so it needs no valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      ir_q       <= '0;
      ir_addr_q  <= '0;
      ir_valid_q <= 1'b0;
      skid_data  <= '0;
      skid_addr  <= '0;
    end else begin
      if (capture) addr_q <= PC;
      if (flush) begin
        ir_valid_q <= 1'b0;
      end else if (take_mem) begin
        ir_q       <= bus.mem_data;
        ir_addr_q  <= addr_q;
        ir_valid_q <= 1'b1;
      end else if (take_skid) begin
        ir_q       <= skid_data;
        ir_addr_q  <= skid_addr;
        ir_valid_q <= 1'b1;
      end else if (ir_valid_q && bus.ir_ready) begin
        ir_valid_q <= 1'b0;
      end
      if (to_skid) begin
        skid_data <= bus.mem_data;
        skid_addr <= addr_q;
      end
    end
  end

  assign pc_ce        = ~rst & (inc | flush);
  assign bus.mem_req  = req;
  assign bus.mem_addr = addr_q;
  assign bus.IR       = ir_q;
  assign bus.ir_addr  = ir_addr_q;
  assign bus.ir_valid = ir_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC counter, delayed-ack memory, queue-based
// fetch model compared every cycle, plus directed literal checks.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] target = '0;
  logic [15:0] pc_rst = '0;
  logic [15:0] pc;
  logic        pc_ce;
  int unsigned delay = 0;
  int unsigned cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk   (clk),
    .rst   (rst),
    .PC    (pc),
    .pc_ce (pc_ce),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [15:0] a);
    return a ^ 16'hBEEF;
  endfunction

  // Program counter: load pin wins over increment.
  always @(posedge clk) begin
    if (rst)        pc <= pc_rst;
    else if (pc_ce) pc <= flush ? target : pc + 16'd1;
  end

  // Memory: acks after `delay` wait cycles of a held request.
  always @(posedge clk) begin
    if (rst || !bus.mem_req || bus.mem_ack) cnt <= 0;
    else                                    cnt <= cnt + 1;
  end
  assign bus.mem_ack  = bus.mem_req && (cnt >= delay);
  assign bus.mem_data = bus.mem_ack ? word(bus.mem_addr) : 16'hDEAD;
  assign bus.ir_ready = ready;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: q holds words handed to the decoder (front = IR, second = parked word).
  typedef struct packed { logic [15:0] a; logic [15:0] d; } ent_t;
  ent_t        q[$];
  logic        m_cap, m_busy, m_drain;
  logic [15:0] m_addr;

  always @(negedge clk) begin
    logic ack, popped, e_pce;
    if (rst) begin
      q.delete();
      m_cap = 1'b1; m_busy = 1'b0; m_drain = 1'b0; m_addr = '0;
    end else begin
      ack   = bus.mem_ack;
      e_pce = flush
            | (m_busy & !m_drain & ack & (q.size() == 0 || (q.size() == 1 && ready)))
            | (!m_busy & !m_cap & q.size() == 2 & ready);
      chk("mem_req",  16'(bus.mem_req),  16'(m_busy));
      chk("mem_addr", bus.mem_addr,      m_addr);
      chk("ir_valid", 16'(bus.ir_valid), 16'(q.size() > 0));
      chk("pc_ce",    16'(pc_ce),        16'(e_pce));
      if (q.size() > 0) begin
        chk("IR",      bus.IR,      q[0].d);
        chk("ir_addr", bus.ir_addr, q[0].a);
      end
      if (flush) begin
        q.delete();
        if (m_cap) m_addr = pc;
        else if (m_busy && !ack) m_drain = 1'b1;
        else begin m_busy = 1'b0; m_drain = 1'b0; m_cap = 1'b1; end
      end else begin
        popped = ready && q.size() > 0;
        if (popped) void'(q.pop_front());
        if (m_cap) begin
          m_addr = pc; m_cap = 1'b0; m_busy = 1'b1; m_drain = 1'b0;
        end else if (m_busy) begin
          if (ack) begin
            m_busy = 1'b0;
            if (m_drain) begin
              m_drain = 1'b0; m_cap = 1'b1;
            end else begin
              q.push_back('{a: m_addr, d: bus.mem_data});
              if (q.size() == 1) m_cap = 1'b1;
            end
          end
        end else if (popped) begin
          m_cap = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset (fetch FSM in LOAD).
  task automatic start(input logic [15:0] pcv, input int unsigned dly, input logic rdy);
    rst = 1'b1; flush = 1'b0; pc_rst = pcv; delay = dly; ready = rdy;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_req",  16'(bus.mem_req),  16'h0);
    chk("rst_pc_ce",    16'(pc_ce),        16'h0);
    chk("rst_ir_valid", 16'(bus.ir_valid), 16'h0);
    chk("rst_IR",       bus.IR,            16'h0000);
    chk("rst_ir_addr",  bus.ir_addr,       16'h0000);
    chk("rst_mem_addr", bus.mem_addr,      16'h0000);
  endtask

  initial begin
    int pulses;

    // Ack tied high from PC 0
    start(16'h0000, 0, 1'b1);
    #1 chk_reset_outputs();
    cyc(); #1;
    chk("a_req", 16'(bus.mem_req), 16'h1); chk("a_addr", bus.mem_addr, 16'h0000); chk("a_pce", 16'(pc_ce), 16'h1);
    cyc(); #1;
    chk("a_valid", 16'(bus.ir_valid), 16'h1); chk("a_IR", bus.IR, 16'hBEEF);
    chk("a_iraddr", bus.ir_addr, 16'h0000); chk("a_req_gap", 16'(bus.mem_req), 16'h0);
    cyc(); #1;
    chk("a_addr2", bus.mem_addr, 16'h0001); chk("a_req2", 16'(bus.mem_req), 16'h1);
    cyc(); #1;
    chk("a_IR2", bus.IR, 16'hBEEE); chk("a_iraddr2", bus.ir_addr, 16'h0001);

    // Three-cycle ack at 0x0010
    start(16'h0010, 2, 1'b1);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("b_req", 16'(bus.mem_req), 16'h1);
      chk("b_addr", bus.mem_addr, 16'h0010);
      pulses += int'(pc_ce);
    end
    chk("b_pulses", 16'(pulses), 16'd1);
    cyc(); #1;
    chk("b_IR", bus.IR, 16'hBEFF); chk("b_iraddr", bus.ir_addr, 16'h0010); chk("b_pce", 16'(pc_ce), 16'h0);

    // Decoder stalled: second word parks in the skid buffer
    start(16'h0040, 0, 1'b0);
    cyc(); cyc(); cyc(); #1;
    chk("c_addr", bus.mem_addr, 16'h0041); chk("c_skid_pce", 16'(pc_ce), 16'h0);
    cyc(); #1;
    chk("c_hold_req", 16'(bus.mem_req), 16'h0); chk("c_hold_IR", bus.IR, 16'hBEAF);
    cyc();
    ready = 1'b1;
    #1 chk("c_release_pce", 16'(pc_ce), 16'h1);
    cyc();
    ready = 1'b0;
    #1;
    chk("c_IR2", bus.IR, 16'hBEAE); chk("c_iraddr2", bus.ir_addr, 16'h0041);
    chk("c_valid2", 16'(bus.ir_valid), 16'h1); chk("c_pce2", 16'(pc_ce), 16'h0);

    // Flush while waiting on 0x0020 -> DRAIN, then fetch from 0x0100
    start(16'h0020, 4, 1'b1);
    cyc();
    flush = 1'b1; target = 16'h0100;
    #1 chk("d_flush_pce", 16'(pc_ce), 16'h1);
    cyc();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("d_drain_req", 16'(bus.mem_req), 16'h1); chk("d_drain_addr", bus.mem_addr, 16'h0020);
      cyc();
    end
    #1 chk("d_drain_ack_pce", 16'(pc_ce), 16'h0);
    cyc(); #1;
    chk("d_valid", 16'(bus.ir_valid), 16'h0); chk("d_load_req", 16'(bus.mem_req), 16'h0);
    cyc();
    delay = 0;
    #1;
    chk("d_tgt_addr", bus.mem_addr, 16'h0100); chk("d_tgt_pce", 16'(pc_ce), 16'h1);
    cyc(); #1;
    chk("d_IR", bus.IR, 16'hBFEF); chk("d_iraddr", bus.ir_addr, 16'h0100);

    // Flush coincident with ack
    start(16'h0030, 0, 1'b1);
    cyc();
    flush = 1'b1; target = 16'h0200;
    #1 chk("e_pce", 16'(pc_ce), 16'h1);
    cyc();
    flush = 1'b0;
    #1 chk("e_valid", 16'(bus.ir_valid), 16'h0);
    cyc(); #1;
    chk("e_addr", bus.mem_addr, 16'h0200); chk("e_req", 16'(bus.mem_req), 16'h1);
    cyc(); #1;
    chk("e_IR", bus.IR, 16'hBCEF); chk("e_iraddr", bus.ir_addr, 16'h0200);

    // Reset during DRAIN
    start(16'h0050, 5, 1'b1);
    cyc();
    flush = 1'b1; target = 16'h0300;
    cyc();
    flush = 1'b0;
    #1 chk("f_drain_req", 16'(bus.mem_req), 16'h1);
    rst = 1'b1; pc_rst = 16'h0060;
    cyc();
    rst = 1'b0; delay = 0;
    #1 chk_reset_outputs();
    cyc(); #1;
    chk("f_restart_addr", bus.mem_addr, 16'h0060); chk("f_restart_req", 16'(bus.mem_req), 16'h1);

    // Reset during HOLD
    start(16'h0070, 0, 1'b0);
    cyc(); cyc(); cyc(); cyc(); #1;
    chk("g_hold_req", 16'(bus.mem_req), 16'h0); chk("g_hold_valid", 16'(bus.ir_valid), 16'h1);
    rst = 1'b1; pc_rst = 16'h0080;
    cyc();
    rst = 1'b0;
    #1 chk_reset_outputs();
    ready = 1'b1;
    cyc(); cyc(); #1;
    chk("g_IR", bus.IR, 16'hBE6F); chk("g_iraddr", bus.ir_addr, 16'h0080);

    // Mixed pattern across the PC wrap, checked by the model each cycle
    start(16'hFFFE, 0, 1'b1);
    for (int i = 0; i < 240; i++) begin
      cyc();
      ready  = (i % 5) != 2;
      delay  = (i / 9) % 4;
      flush  = (i % 29) == 17;
      target = 16'h0400 + 16'(i);
      pc_rst = 16'h1000;
      rst    = (i == 200);
    end
    cyc();
    rst = 1'b0; flush = 1'b0; ready = 1'b1;
    repeat (10) cyc();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
